ysyx_220053_ifu: RTL and testbench

//   Instruction fetch stage that sits directly upstream of the execute unit.
//   It owns the PC, issues one 32-bit fetch at a time to instruction memory

---
 rtl/ysyx_220053_ifu_if.sv | 36 +++
 rtl/ysyx_220053_ifu.sv | 128 ++++++++++++
 tb/tb_ysyx_220053_ifu.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_220053_ifu_if.sv
// Fetch-stage bus bundle: imem request/response, redirect input and instruction output.
// No latency of its own; it only carries wires.
// Backpressure: imem_req_ready stalls requests and inst_ready stalls instruction hand-off.
//
// Ports (master = fetch unit side):
//   imem_req_valid/imem_req_ready/imem_req_addr : fetch request, valid/ready
//   imem_rsp_valid/imem_rsp_data                : fetch response, valid-only
//   redirect_valid/redirect_pc                  : PC redirect from later stages
//   inst_valid/inst_ready/inst/inst_pc          : fetched instruction to execute
interface ysyx_220053_ifu_if #(
    parameter int XLEN = 64
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            inst_valid;
    logic            inst_ready;
    logic [31:0]     inst;
    logic [XLEN-1:0] inst_pc;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/ysyx_220053_ifu.sv
// Instruction fetch stage: owns the PC, one outstanding 32-bit fetch, holds the result for execute.
// Latency: request 1 cycle after reset; best case one instruction every 3 cycles (REQ, WAIT, HOLD).
// Backpressure: waits in REQ until imem_req_ready, and holds inst/inst_pc stable until inst_ready.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : ysyx_220053_ifu_if.master (imem request/response, redirect, instruction output)
module ysyx_220053_ifu #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
    input  logic                 clk,
    input  logic                 rst,
    ysyx_220053_ifu_if.master    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t          state, state_n;
    logic [XLEN-1:0] pc, pc_n;
    logic            drop, drop_n;
    logic [31:0]     inst_q, inst_n;
    logic [XLEN-1:0] inst_pc_q, inst_pc_n;

    logic [XLEN-1:0] redirect_aligned;
    logic            req_fire;
    logic            inst_fire;

    // Instructions are word aligned, so the low two target bits are discarded.
    assign redirect_aligned = {bus.redirect_pc[XLEN-1:2], 2'b00};

    // A redirect suppresses both outgoing valids in the same cycle, so no
    // handshake can complete on a path that is being flushed.
    assign bus.imem_req_valid = (state == REQ) && !bus.redirect_valid;
    assign bus.imem_req_addr  = pc;
    assign bus.inst_valid     = (state == HOLD) && !bus.redirect_valid;
    assign bus.inst           = inst_q;
    assign bus.inst_pc        = inst_pc_q;

    assign req_fire  = bus.imem_req_valid && bus.imem_req_ready;
    assign inst_fire = bus.inst_valid && bus.inst_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            drop      <= 1'b0;
            inst_q    <= 32'd0;
            inst_pc_q <= '0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            drop      <= drop_n;
            inst_q    <= inst_n;
            inst_pc_q <= inst_pc_n;
        end
    end

    always_comb begin
        state_n   = state;
        pc_n      = pc;
        drop_n    = drop;
        inst_n    = inst_q;
        inst_pc_n = inst_pc_q;

        unique case (state)
            IDLE: begin
                state_n = REQ;
                if (bus.redirect_valid) begin
                    pc_n = redirect_aligned;
                end
            end

            REQ: begin
                if (bus.redirect_valid) begin
                    pc_n = redirect_aligned;
                end else if (req_fire) begin
                    state_n = WAIT;
                end
            end

            WAIT: begin
                if (bus.redirect_valid) begin
                    pc_n = redirect_aligned;
                    if (bus.imem_rsp_valid) begin
                        // The in-flight response lands now and is thrown away,
                        // so there is nothing left to drop later.
                        drop_n  = 1'b0;
                        state_n = REQ;
                    end else begin
                        // Response still owed by memory; swallow it on arrival.
                        drop_n = 1'b1;
                    end
                end else if (bus.imem_rsp_valid) begin
                    if (drop) begin
                        drop_n  = 1'b0;
                        state_n = REQ;
                    end else begin
                        inst_n    = bus.imem_rsp_data;
                        inst_pc_n = pc;
                        state_n   = HOLD;
                    end
                end
            end

            HOLD: begin
                if (bus.redirect_valid) begin
                    pc_n    = redirect_aligned;
                    state_n = REQ;
                end else if (inst_fire) begin
                    pc_n    = pc + XLEN'(4);
                    state_n = REQ;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ysyx_220053_ifu.sv
// Testbench for ysyx_220053_ifu: directed scenarios followed by randomized traffic,
// compared against a transaction-level reference model (queues of outstanding
// requests and held instructions).
module tb_ysyx_220053_ifu;

    localparam int          XLEN     = 64;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    ysyx_220053_ifu_if #(.XLEN(XLEN)) bus ();

    ysyx_220053_ifu #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state.
    typedef struct {
        logic [31:0] ins;
        logic [63:0] pc;
    } held_t;

    logic [63:0] m_pc;
    bit          m_boot;    // first cycle after reset release: no request yet
    bit          oq[$];     // outstanding fetches; entry = 1 when already stale
    held_t       hq[$];     // instruction waiting for downstream

    // Samples of DUT outputs taken in the last cycle.
    logic        s_req_valid, s_inst_valid;
    logic [63:0] s_req_addr, s_inst_pc;
    logic [31:0] s_inst;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc   = RESET_PC;
        m_boot = 1'b1;
        oq.delete();
        hq.delete();
    endtask

    // One clock of the reference model, given this cycle's inputs.
    task automatic model_step(input bit rr, input bit rv, input logic [31:0] rd,
                              input bit rdv, input logic [63:0] rpc, input bit ir);
        bit    requesting;
        held_t h;
        requesting = !m_boot && oq.size() == 0 && hq.size() == 0;
        if (m_boot) begin
            m_boot = 1'b0;
            if (rdv) m_pc = rpc & ~64'h3;
        end else if (rdv) begin
            m_pc = rpc & ~64'h3;
            if (oq.size() != 0) begin
                if (rv) oq.delete();
                else    oq[0] = 1'b1;
            end
            hq.delete();
        end else if (requesting) begin
            if (rr) oq.push_back(1'b0);
        end else if (oq.size() != 0) begin
            if (rv) begin
                if (!oq[0]) begin
                    h.ins = rd;
                    h.pc  = m_pc;
                    hq.push_back(h);
                end
                oq.delete();
            end
        end else if (hq.size() != 0 && ir) begin
            hq.delete();
            m_pc = m_pc + 64'd4;
        end
    endtask

    // Drive one cycle of inputs, compare DUT against the model at the falling
    // edge, then advance both across the rising edge.
    task automatic cyc(input bit rr, input bit rv, input logic [31:0] rd,
                       input bit rdv, input logic [63:0] rpc, input bit ir);
        bit exp_req_valid, exp_inst_valid;
        bus.imem_req_ready = rr;
        bus.imem_rsp_valid = rv;
        bus.imem_rsp_data  = rd;
        bus.redirect_valid = rdv;
        bus.redirect_pc    = rpc;
        bus.inst_ready     = ir;
        @(negedge clk);
        s_req_valid  = bus.imem_req_valid;
        s_req_addr   = bus.imem_req_addr;
        s_inst_valid = bus.inst_valid;
        s_inst       = bus.inst;
        s_inst_pc    = bus.inst_pc;
        exp_req_valid  = !m_boot && oq.size() == 0 && hq.size() == 0 && !rdv;
        exp_inst_valid = hq.size() != 0 && !rdv;
        chk("m_req_valid", {63'd0, s_req_valid}, {63'd0, exp_req_valid});
        chk("m_req_addr", s_req_addr, m_pc);
        chk("m_inst_valid", {63'd0, s_inst_valid}, {63'd0, exp_inst_valid});
        if (exp_inst_valid) begin
            chk("m_inst", {32'd0, s_inst}, {32'd0, hq[0].ins});
            chk("m_inst_pc", s_inst_pc, hq[0].pc);
        end
        model_step(rr, rv, rd, rdv, rpc, ir);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, {63'd0, bus.imem_req_valid}, 64'd0);
        chk({tag, "_inst_valid"}, {63'd0, bus.inst_valid}, 64'd0);
        chk({tag, "_inst"}, {32'd0, bus.inst}, 64'd0);
        chk({tag, "_inst_pc"}, bus.inst_pc, 64'd0);
        chk({tag, "_req_addr"}, bus.imem_req_addr, RESET_PC);
    endtask

    initial begin
        bit          rr, rv, rdv, ir;
        logic [31:0] rd;
        logic [63:0] rpc;

        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'd0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 64'd0;
        bus.inst_ready     = 1'b0;
        model_reset();

        // Power-on reset.
        @(negedge clk);
        chk_reset_outputs("por");
        @(posedge clk);
        #1 rst = 1'b0;

        // 1: first fetch with everything ready.
        cyc(1, 0, 32'd0, 0, 64'd0, 1);
        chk("t1_idle_no_req", {63'd0, s_req_valid}, 64'd0);
        cyc(1, 0, 32'd0, 0, 64'd0, 1);
        chk("t1_req_valid", {63'd0, s_req_valid}, 64'd1);
        chk("t1_req_addr", s_req_addr, 64'h8000_0000);
        cyc(1, 1, 32'h0010_0093, 0, 64'd0, 1);
        chk("t1_wait_no_inst", {63'd0, s_inst_valid}, 64'd0);
        cyc(1, 0, 32'd0, 0, 64'd0, 1);
        chk("t1_inst_valid", {63'd0, s_inst_valid}, 64'd1);
        chk("t1_inst", {32'd0, s_inst}, 64'h0010_0093);
        chk("t1_inst_pc", s_inst_pc, 64'h8000_0000);
        cyc(1, 0, 32'd0, 0, 64'd0, 0);
        chk("t1_next_req_addr", s_req_addr, 64'h8000_0004);

        // 2: downstream stalls for 5 cycles while an instruction is held.
        cyc(1, 1, 32'hDEAD_BEEF, 0, 64'd0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 32'd0, 0, 64'd0, 0);
            chk("t2_stall_inst_valid", {63'd0, s_inst_valid}, 64'd1);
            chk("t2_stall_inst", {32'd0, s_inst}, 64'hDEAD_BEEF);
            chk("t2_stall_inst_pc", s_inst_pc, 64'h8000_0004);
            chk("t2_stall_no_req", {63'd0, s_req_valid}, 64'd0);
            chk("t2_stall_pc", s_req_addr, 64'h8000_0004);
        end
        cyc(1, 0, 32'd0, 0, 64'd0, 1);
        chk("t2_accept", {63'd0, s_inst_valid}, 64'd1);
        cyc(1, 0, 32'd0, 0, 64'd0, 0);
        chk("t2_next_req_addr", s_req_addr, 64'h8000_0008);

        // 3: redirect while waiting, then the stale response arrives.
        cyc(1, 0, 32'd0, 1, 64'h8000_0103, 0);
        chk("t3_redir_no_req", {63'd0, s_req_valid}, 64'd0);
        cyc(1, 1, 32'h1111_1111, 0, 64'd0, 0);
        chk("t3_drop_no_inst", {63'd0, s_inst_valid}, 64'd0);
        cyc(1, 0, 32'd0, 0, 64'd0, 0);
        chk("t3_no_inst_after_drop", {63'd0, s_inst_valid}, 64'd0);
        chk("t3_req_valid", {63'd0, s_req_valid}, 64'd1);
        chk("t3_req_addr", s_req_addr, 64'h8000_0100);
        cyc(1, 1, 32'h2222_2222, 0, 64'd0, 0);

        // 4: redirect in HOLD together with inst_ready.
        cyc(1, 0, 32'd0, 1, 64'h8000_0200, 1);
        chk("t4_inst_valid_killed", {63'd0, s_inst_valid}, 64'd0);
        cyc(1, 0, 32'd0, 0, 64'd0, 0);
        chk("t4_req_addr", s_req_addr, 64'h8000_0200);

        // 5: PC wrap after the last word of the address space.
        cyc(1, 0, 32'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        cyc(1, 1, 32'h3333_3333, 0, 64'd0, 0);
        cyc(1, 0, 32'd0, 0, 64'd0, 0);
        chk("t5_req_addr_top", s_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        cyc(1, 1, 32'h4444_4444, 0, 64'd0, 0);
        cyc(1, 0, 32'd0, 0, 64'd0, 1);
        chk("t5_inst_pc_top", s_inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        cyc(1, 0, 32'd0, 0, 64'd0, 0);
        chk("t5_wrap_addr", s_req_addr, 64'd0);

        // 6: reset asserted asynchronously while waiting for a response.
        rst = 1'b1;
        model_reset();
        #2;
        chk_reset_outputs("t6_rst");
        @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("t6_rst_hold");
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(0, 1, 32'h5555_5555, 0, 64'd0, 1);
        chk("t6_stray_no_inst", {63'd0, s_inst_valid}, 64'd0);
        cyc(0, 1, 32'h6666_6666, 0, 64'd0, 1);
        chk("t6_req_valid", {63'd0, s_req_valid}, 64'd1);
        chk("t6_req_addr", s_req_addr, RESET_PC);

        // Randomized traffic, including spurious responses and near-wrap redirects.
        for (int n = 0; n < 3000; n++) begin
            rr  = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 2) == 0);
            rd  = $urandom;
            ir  = ($urandom_range(0, 2) != 0);
            rdv = ($urandom_range(0, 9) == 0);
            rpc = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            if (n == 1500) begin
                rst = 1'b1;
                model_reset();
                #2;
                chk_reset_outputs("rnd_rst");
                @(posedge clk);
                #1 rst = 1'b0;
            end
            cyc(rr, rv, rd, rdv, rpc, ir);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
